// File: rtl/cmd_arbiter.sv
// cmd_arbiter: merges NREQ command streams onto one element command port.
// Each requester has a small private FIFO. A round-robin arbiter pops one
// entry per cycle while the element is ready. Overflows are discarded,
// flagged per requester and counted in a saturating drop counter.
module cmd_arbiter #(
    parameter int NREQ  = 4,
    parameter int AW    = 8,
    parameter int CW    = 64,
    parameter int DEPTH = 2,
    localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req_cstrobe,
    input  logic [NREQ*(AW+CW)-1:0] req_cmd,
    input  logic                   el_ready,
    output logic                   cstrobe_out,
    output logic [AW-1:0]          cmda_out,
    output logic [CW-1:0]          command_out,
    output logic [GW-1:0]          grant_id,
    output logic [NREQ-1:0]        collision,
    input  logic                   collision_clr,
    output logic [15:0]            drop_count
);

    localparam int EW   = AW + CW;
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;

    logic [NREQ-1:0] not_empty;
    logic [NREQ-1:0] push;
    logic [NREQ-1:0] pop;
    logic [NREQ-1:0] drop;
    logic [EW-1:0]   head_data [NREQ];

    logic            grant_valid;
    logic [GW-1:0]   grant_idx;
    logic [GW:0]     cand;
    logic [GW-1:0]   rr_ptr_reg;
    logic [16:0]     drops_now;
    logic [16:0]     drop_sum;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_fifo
            logic [EW-1:0]   mem [DEPTH];
            logic [PW-1:0]   wr_ptr_reg;
            logic [PW-1:0]   rd_ptr_reg;
            logic [CNTW-1:0] count_reg;
            logic            full;

            assign full          = (count_reg == CNTW'(DEPTH));
            assign not_empty[gi] = (count_reg != '0);
            assign pop[gi]       = grant_valid && (grant_idx == GW'(gi));
            // A full FIFO still accepts a push when it is popped in the same cycle.
            assign push[gi]      = req_cstrobe[gi] && (!full || pop[gi]);
            assign drop[gi]      = req_cstrobe[gi] && full && !pop[gi];
            assign head_data[gi] = mem[rd_ptr_reg];

            // Storage array: written on push, no reset needed since pointers define validity.
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg] <= req_cmd[gi*EW +: EW];
                end
            end

            // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    count_reg <= count_reg + CNTW'(push[gi]) - CNTW'(pop[gi]);
                end
            end
        end
    endgenerate

    // Round-robin search: first non-empty FIFO at or after rr_ptr, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_reg} + (GW+1)'(k);
            if (cand >= (GW+1)'(NREQ)) cand = cand - (GW+1)'(NREQ);
            if (!grant_valid && not_empty[cand[GW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[GW-1:0];
            end
        end
        grant_valid = grant_valid && el_ready;
    end

    // Number of commands discarded this cycle, added to the saturating counter.
    always_comb begin
        drops_now = '0;
        for (int k = 0; k < NREQ; k++) begin
            drops_now = drops_now + 17'(drop[k]);
        end
        drop_sum = {1'b0, drop_count} + drops_now;
    end

    // Round-robin pointer advances past the winner only when a grant happens.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_reg <= '0;
        end else if (grant_valid) begin
            rr_ptr_reg <= (grant_idx == GW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Registered element-side outputs; data fields hold when no grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cstrobe_out <= 1'b0;
            cmda_out    <= '0;
            command_out <= '0;
            grant_id    <= '0;
        end else begin
            cstrobe_out <= grant_valid;
            if (grant_valid) begin
                cmda_out    <= head_data[grant_idx][EW-1 -: AW];
                command_out <= head_data[grant_idx][CW-1:0];
                grant_id    <= grant_idx;
            end
        end
    end

    // Sticky overflow flags (a new drop beats a clear) and saturating drop total.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            collision  <= '0;
            drop_count <= '0;
        end else begin
            collision  <= (collision & ~{NREQ{collision_clr}}) | drop;
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

endmodule

// File: tb/tb_cmd_arbiter.sv
// tb_cmd_arbiter: table-driven single-command vectors plus hand-written
// sequences for contention, overflow, clear/set, saturation and reset.
// A scoreboard queue holds expected issues; a monitor pops on each strobe.
module tb_cmd_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int CW   = 64;
    localparam int EW   = AW + CW;

    logic                   clk;
    logic                   reset_n;
    logic [NREQ-1:0]        req_cstrobe;
    logic [NREQ*EW-1:0]     req_cmd;
    logic                   el_ready;
    logic                   cstrobe_out;
    logic [AW-1:0]          cmda_out;
    logic [CW-1:0]          command_out;
    logic [1:0]             grant_id;
    logic [NREQ-1:0]        collision;
    logic                   collision_clr;
    logic [15:0]            drop_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [7:0]  cmda;
        logic [63:0] data;
    } cmd_t;

    cmd_t sb[$];
    cmd_t vecs[4];

    cmd_arbiter #(.NREQ(NREQ), .AW(AW), .CW(CW), .DEPTH(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_cstrobe   (req_cstrobe),
        .req_cmd       (req_cmd),
        .el_ready      (el_ready),
        .cstrobe_out   (cstrobe_out),
        .cmda_out      (cmda_out),
        .command_out   (command_out),
        .grant_id      (grant_id),
        .collision     (collision),
        .collision_clr (collision_clr),
        .drop_count    (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cmd_t mk(input int id, input logic [7:0] a, input logic [63:0] d);
        cmd_t c;
        c.id   = id;
        c.cmda = a + 8'(id);
        c.data = d + 64'(id);
        return c;
    endfunction

    // Strobe the masked requesters for one cycle; requester i gets {a+i, d+i}.
    task automatic pulse(input logic [3:0] mask, input logic [7:0] a, input logic [63:0] d);
        for (int i = 0; i < NREQ; i++) begin
            if (mask[i]) req_cmd[i*EW +: EW] = {a + 8'(i), d + 64'(i)};
        end
        req_cstrobe = mask;
        @(negedge clk);
        req_cstrobe = '0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_remaining", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every issued command must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && cstrobe_out) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got id=%0d cmda=%0h cmd=%0h required no strobe",
                         grant_id, cmda_out, command_out);
            end else begin
                cmd_t e;
                e = sb.pop_front();
                if (grant_id !== 2'(e.id) || cmda_out !== e.cmda || command_out !== e.data) begin
                    errors++;
                    $display("FAIL issue: got id=%0d cmda=%0h cmd=%0h required id=%0d cmda=%0h cmd=%0h",
                             grant_id, cmda_out, command_out, e.id, e.cmda, e.data);
                end else begin
                    $display("issue id=%0d cmda=%0h cmd=%0h ok", grant_id, cmda_out, command_out);
                end
            end
        end
    end

    initial begin
        int n;
        vecs[0] = '{2, 8'h05, 64'hDEAD_BEEF_0000_0001};
        vecs[1] = '{0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2] = '{1, 8'h00, 64'h0000_0000_0000_0000};
        vecs[3] = '{3, 8'hA5, 64'h0123_4567_89AB_CDEF};

        reset_n       = 1'b0;
        req_cstrobe   = '0;
        req_cmd       = '0;
        el_ready      = 1'b0;
        collision_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cstrobe", 64'(cstrobe_out), 64'd0);
        check("rst_cmda", 64'(cmda_out), 64'd0);
        check("rst_command", command_out, 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_collision", 64'(collision), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        reset_n  = 1'b1;
        el_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_strobe", 64'(cstrobe_out), 64'd0);

        // Single commands: exact 2-cycle latency, one-cycle pulse, outputs hold.
        for (int i = 0; i < 4; i++) begin
            req_cmd[vecs[i].id*EW +: EW] = {vecs[i].cmda, vecs[i].data};
            req_cstrobe = 4'(1 << vecs[i].id);
            sb.push_back(vecs[i]);
            @(negedge clk);
            req_cstrobe = '0;
            check("lat_t1", 64'(cstrobe_out), 64'd0);
            @(negedge clk);
            check("lat_t2", 64'(cstrobe_out), 64'd1);
            @(negedge clk);
            check("pulse_end", 64'(cstrobe_out), 64'd0);
            check("hold_cmda", 64'(cmda_out), 64'(vecs[i].cmda));
            check("hold_grant_id", 64'(grant_id), 64'(vecs[i].id));
        end

        // Contention: two simultaneous bursts, each granted 0,1,2,3 back to back.
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) sb.push_back(mk(i, 8'h10 + 8'(b*16), 64'h1000 + 64'(b*256)));
            pulse(4'hF, 8'h10 + 8'(b*16), 64'h1000 + 64'(b*256));
            for (int c = 0; c < 6; c++) begin
                check("burst_strobe", 64'(cstrobe_out), (c >= 1 && c <= 4) ? 64'd1 : 64'd0);
                @(negedge clk);
            end
        end

        // Overflow on requester 1 while stalled: third command dropped.
        el_ready = 1'b0;
        sb.push_back(mk(1, 8'h20, 64'h100));
        pulse(4'b0010, 8'h20, 64'h100);
        sb.push_back(mk(1, 8'h21, 64'h101));
        pulse(4'b0010, 8'h21, 64'h101);
        pulse(4'b0010, 8'h22, 64'h102);
        check("stall_no_strobe", 64'(cstrobe_out), 64'd0);
        check("ovf_collision", 64'(collision), 64'h2);
        check("ovf_drop_count", 64'(drop_count), 64'd1);
        el_ready = 1'b1;
        wait_drain(10);

        // Full FIFO pushed and popped in the same cycle: nothing dropped.
        el_ready = 1'b0;
        sb.push_back(mk(0, 8'h30, 64'h200));
        pulse(4'b0001, 8'h30, 64'h200);
        sb.push_back(mk(0, 8'h31, 64'h201));
        pulse(4'b0001, 8'h31, 64'h201);
        el_ready = 1'b1;
        sb.push_back(mk(0, 8'h32, 64'h202));
        pulse(4'b0001, 8'h32, 64'h202);
        check("pushpop_drop_count", 64'(drop_count), 64'd1);
        check("pushpop_collision", 64'(collision), 64'h2);
        wait_drain(10);

        // Clear coincides with a new overflow on requester 3: set wins there.
        el_ready = 1'b0;
        pulse(4'b0001, 8'h40, 64'h300);
        pulse(4'b0001, 8'h41, 64'h301);
        pulse(4'b0001, 8'h42, 64'h302);
        check("pre_clr_collision", 64'(collision), 64'h3);
        check("pre_clr_drop_count", 64'(drop_count), 64'd2);
        pulse(4'b1000, 8'h50, 64'h400);
        pulse(4'b1000, 8'h51, 64'h401);
        collision_clr = 1'b1;
        pulse(4'b1000, 8'h52, 64'h402);
        collision_clr = 1'b0;
        check("clr_set_collision", 64'(collision), 64'h8);
        check("clr_set_drop_count", 64'(drop_count), 64'd3);
        collision_clr = 1'b1;
        @(negedge clk);
        collision_clr = 1'b0;
        check("clr_only_collision", 64'(collision), 64'h0);
        check("clr_keeps_drop_count", 64'(drop_count), 64'd3);
        // Round-robin pointer sits at 1, so requester 3 and 0 alternate, 3 first.
        sb.push_back(mk(3, 8'h50, 64'h400));
        sb.push_back(mk(0, 8'h40, 64'h300));
        sb.push_back(mk(3, 8'h51, 64'h401));
        sb.push_back(mk(0, 8'h41, 64'h301));
        el_ready = 1'b1;
        wait_drain(10);

        // Saturation: fill every FIFO, then overflow all four for many cycles.
        el_ready = 1'b0;
        pulse(4'hF, 8'h60, 64'h500);
        pulse(4'hF, 8'h61, 64'h501);
        check("fill_drop_count", 64'(drop_count), 64'd3);
        pulse(4'hF, 8'h62, 64'h502);
        check("multi_drop_count", 64'(drop_count), 64'd7);
        check("multi_collision", 64'(collision), 64'hF);
        req_cstrobe = 4'hF;
        repeat (17500) @(negedge clk);
        req_cstrobe = '0;
        check("sat_drop_count", 64'(drop_count), 64'hFFFF);
        pulse(4'hF, 8'h63, 64'h503);
        check("sat_hold", 64'(drop_count), 64'hFFFF);

        // Reset mid-stream with two entries queued per requester.
        sb.push_back(mk(1, 8'h60, 64'h500));
        el_ready = 1'b1;
        @(negedge clk);
        check("pre_reset_strobe", 64'(cstrobe_out), 64'd1);
        #2;
        reset_n  = 1'b0;
        el_ready = 1'b0;
        #1;
        check("async_rst_cstrobe", 64'(cstrobe_out), 64'd0);
        check("async_rst_cmda", 64'(cmda_out), 64'd0);
        check("async_rst_command", command_out, 64'd0);
        check("async_rst_grant_id", 64'(grant_id), 64'd0);
        check("async_rst_collision", 64'(collision), 64'd0);
        check("async_rst_drop_count", 64'(drop_count), 64'd0);
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        el_ready = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (cstrobe_out) n++;
        end
        check("post_reset_strobes", 64'(n), 64'd0);

        // Normal service resumes after reset.
        sb.push_back(mk(2, 8'h70, 64'h600));
        pulse(4'b0100, 8'h70, 64'h600);
        wait_drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
